taxi_eth_tx_frame_arb: RTL and testbench

Frame-level transmit arbiter that shares one 1G MAC transmit AXI-stream sink among `PORTS` independent frame sources. Grants are decided only at frame boundaries, so a granted frame is never interleaved with another. A per-frame stall watchdog aborts a frame whose source stops supplying data, so a dead requester cannot hold the MAC. The block sits directly in front of the MAC `s_axis_tx` port, in the MAC `tx_clk` domain.

---
 rtl/taxi_eth_tx_frame_arb.sv | 192 +++++++++++++++++++
 tb/tb_taxi_eth_tx_frame_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_eth_tx_frame_arb.sv
// Frame-level transmit arbiter sharing one MAC tx AXI-stream sink among PORTS sources, with a stall watchdog.
// Optional feature macro: TAXI_TX_ARB_PRIO_EN gives port 0 strict priority over the round-robin ports.
module taxi_eth_tx_frame_arb #(
   parameter int PORTS   = 4,
   parameter int DATA_W  = 8,
   parameter int USER_W  = 1,
   parameter int TIMEOUT = 1024,
   localparam int IDX_W  = $clog2(PORTS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [PORTS*DATA_W-1:0]   s_tdata,
   input  logic [PORTS-1:0]          s_tvalid,
   output logic [PORTS-1:0]          s_tready,
   input  logic [PORTS-1:0]          s_tlast,
   input  logic [PORTS*USER_W-1:0]   s_tuser,
   output logic [DATA_W-1:0]         m_tdata,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast,
   output logic [USER_W-1:0]         m_tuser,
   output logic                      grant_valid,
   output logic [IDX_W-1:0]          grant_idx,
   output logic [PORTS-1:0]          abort
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      ABORT = 2'd2,
      DROP  = 2'd3
   } state_t;

   localparam logic [15:0] STALL_LIM = 16'(TIMEOUT - 1);

   state_t             state, state_d;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [15:0]        stall_cnt, stall_cnt_d;
   logic               grant_valid_q;
   logic [PORTS-1:0]   abort_q, abort_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   cand_idx;
   logic [IDX_W-1:0]   rr_next;

   logic               g_tvalid;
   logic               g_tlast;
   logic [DATA_W-1:0]  g_tdata;
   logic [USER_W-1:0]  g_tuser;

   logic [DATA_W-1:0]  m_tdata_c;
   logic               m_tvalid_c;
   logic               m_tlast_c;
   logic [USER_W-1:0]  m_tuser_c;
   logic [PORTS-1:0]   s_tready_c;

   // Granted-source view; the grant index only ever holds a picked port number.
   always_comb begin
      g_tvalid = s_tvalid[grant_q];
      g_tlast  = s_tlast[grant_q];
      g_tdata  = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
      g_tuser  = s_tuser[int'(grant_q)*USER_W +: USER_W];
   end

   // First valid port searching upward from rr_ptr+1, wrapping at PORTS.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
`ifdef TAXI_TX_ARB_PRIO_EN
      if (s_tvalid[0]) begin
         pick_found = 1'b1;
      end
`endif
      for (int k = 1; k <= PORTS; k++) begin
         cand_idx = IDX_W'((int'(rr_ptr) + k) % PORTS);
         if (!pick_found && s_tvalid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Port 0 grants in priority mode leave the round-robin pointer untouched.
   always_comb begin
`ifdef TAXI_TX_ARB_PRIO_EN
      rr_next = (grant_q == '0) ? rr_ptr : grant_q;
`else
      rr_next = grant_q;
`endif
   end

   always_comb begin
      state_d     = state;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr;
      stall_cnt_d = stall_cnt;
      abort_d     = '0;
      m_tdata_c   = '0;
      m_tvalid_c  = 1'b0;
      m_tlast_c   = 1'b0;
      m_tuser_c   = '0;
      s_tready_c  = '0;

      case (state)
         IDLE: begin
            stall_cnt_d = '0;
            if (enable && pick_found) begin
               grant_d = pick_idx;
               state_d = XFER;
            end
         end

         XFER: begin
            m_tdata_c  = g_tdata;
            m_tvalid_c = g_tvalid;
            m_tlast_c  = g_tlast;
            m_tuser_c  = g_tuser;
            s_tready_c[grant_q] = m_tready;

            // Only a silent source counts as a stall; MAC backpressure does not.
            if (g_tvalid) begin
               stall_cnt_d = '0;
            end else if (stall_cnt != 16'hffff) begin
               stall_cnt_d = stall_cnt + 16'd1;
            end

            if (g_tvalid && m_tready && g_tlast) begin
               rr_ptr_d = rr_next;
               state_d  = IDLE;
            end else if (TIMEOUT != 0 && !g_tvalid && stall_cnt == STALL_LIM) begin
               abort_d[grant_q] = 1'b1;
               state_d          = ABORT;
            end
         end

         ABORT: begin
            // Synthetic errored end-of-frame so the MAC discards the partial frame.
            m_tvalid_c   = 1'b1;
            m_tlast_c    = 1'b1;
            m_tuser_c[0] = 1'b1;
            if (m_tready) begin
               state_d = DROP;
            end
         end

         DROP: begin
            s_tready_c[grant_q] = 1'b1;
            if (g_tvalid && g_tlast) begin
               rr_ptr_d = rr_next;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         rr_ptr        <= IDX_W'(PORTS - 1);
         grant_q       <= '0;
         stall_cnt     <= '0;
         grant_valid_q <= 1'b0;
         abort_q       <= '0;
      end else begin
         state         <= state_d;
         rr_ptr        <= rr_ptr_d;
         grant_q       <= grant_d;
         stall_cnt     <= stall_cnt_d;
         grant_valid_q <= (state_d != IDLE);
         abort_q       <= abort_d;
      end
   end

   // Outputs are forced low while reset is asserted, even before the first reset edge.
   assign m_tdata     = rst_n ? m_tdata_c : '0;
   assign m_tvalid    = rst_n & m_tvalid_c;
   assign m_tlast     = rst_n & m_tlast_c;
   assign m_tuser     = rst_n ? m_tuser_c : '0;
   assign s_tready    = rst_n ? s_tready_c : '0;
   assign grant_valid = rst_n & grant_valid_q;
   assign grant_idx   = rst_n ? grant_q : '0;
   assign abort       = rst_n ? abort_q : '0;

endmodule

// File: tb/tb_taxi_eth_tx_frame_arb.sv
// Directed bench for taxi_eth_tx_frame_arb: 4 ports, 8-bit data, TIMEOUT=16.
module tb_taxi_eth_tx_frame_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [31:0] s_tdata;
   logic [3:0]  s_tvalid;
   logic [3:0]  s_tready;
   logic [3:0]  s_tlast;
   logic [3:0]  s_tuser;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [0:0]  m_tuser;
   logic        grant_valid;
   logic [1:0]  grant_idx;
   logic [3:0]  abort;

   taxi_eth_tx_frame_arb #(
      .PORTS(4), .DATA_W(8), .USER_W(1), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_tuser(m_tuser),
      .grant_valid(grant_valid), .grant_idx(grant_idx), .abort(abort)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation ran past its time limit");
      $fatal(1);
   end

   // Expected beat word: {tuser, tlast, data}; source data is {port[1:0], beat[5:0]}.
   logic [9:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   int         src_len[4];
   int         src_frames[4];
   int         src_beat[4];
   logic [3:0] src_hold;

   int         obs_cyc;
   logic       obs_acc, obs_mvalid, obs_mready, obs_gv;
   logic [9:0] obs_word;
   logic [1:0] obs_gi;
   logic [3:0] obs_abort, obs_sready;

   task automatic drive();
      for (int p = 0; p < 4; p++) begin
         s_tvalid[p]        = (src_frames[p] > 0) && !src_hold[p];
         s_tdata[p*8 +: 8]  = {2'(p), 6'(src_beat[p])};
         s_tlast[p]         = (src_beat[p] == src_len[p] - 1);
         s_tuser[p]         = 1'b0;
      end
   endtask

   task automatic load(input int p, input int len, input int n);
      src_len[p]    = len;
      src_frames[p] = n;
      src_beat[p]   = 0;
      drive();
   endtask

   task automatic push_frame(input int p, input int len);
      for (int b = 0; b < len; b++)
         exp_q.push_back({1'b0, (b == len - 1), 2'(p), 6'(b)});
   endtask

   // Sample outputs mid-cycle, then advance the source models past the edge.
   task automatic step();
      logic [3:0] hs;
      @(negedge clk);
      obs_cyc    = cyc;
      obs_mvalid = m_tvalid;
      obs_mready = m_tready;
      obs_acc    = m_tvalid & m_tready;
      obs_word   = {m_tuser[0], m_tlast, m_tdata};
      obs_gv     = grant_valid;
      obs_gi     = grant_idx;
      obs_abort  = abort;
      obs_sready = s_tready;
      hs         = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < 4; p++) begin
         if (hs[p]) begin
            if (src_beat[p] == src_len[p] - 1) begin
               src_beat[p] = 0;
               src_frames[p]--;
            end else begin
               src_beat[p]++;
            end
         end
      end
      drive();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; m_tready = 1'b1; src_hold = '0;
      for (int p = 0; p < 4; p++) begin src_len[p] = 4; src_frames[p] = 0; src_beat[p] = 0; end
      src_frames[3] = 1;
      drive();
      step(); step();
      vectors++;
      if ({obs_mvalid, obs_word} !== 11'd0) begin
         miscompares++; $display("FAIL reset_m: got %h expected 0", {obs_mvalid, obs_word});
      end
      vectors++;
      if (obs_sready !== 4'd0) begin
         miscompares++; $display("FAIL reset_s_tready: got %b expected 0000", obs_sready);
      end
      vectors++;
      if ({obs_gv, obs_abort, obs_gi} !== 7'd0) begin
         miscompares++; $display("FAIL reset_grant: got %b expected 0", {obs_gv, obs_abort, obs_gi});
      end
      src_frames[3] = 0; drive();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_round_robin();
      logic [9:0] exp;
      bit first = 1'b1, have_prev = 1'b0;
      int last_cyc = 0, budget = 0;
      for (int p = 0; p < 4; p++) load(p, 64, 2);
      for (int f = 0; f < 2; f++) for (int p = 0; p < 4; p++) push_frame(p, 64);
      while (exp_q.size() > 0 && budget < 1000) begin
         step(); budget++;
         if (obs_acc) begin
            exp = exp_q.pop_front();
            vectors++;
            if (obs_word !== exp) begin
               miscompares++; $display("FAIL rr_beat: got %h expected %h", obs_word, exp);
            end
            if (first) begin
               vectors++;
               if (obs_gi !== exp[7:6]) begin
                  miscompares++; $display("FAIL rr_grant: got %0d expected %0d", obs_gi, exp[7:6]);
               end
               if (have_prev) begin
                  vectors++;
                  if (obs_cyc - last_cyc !== 2) begin
                     miscompares++; $display("FAIL rr_gap: got %0d expected 2", obs_cyc - last_cyc);
                  end
               end
            end
            first = exp[8];
            if (exp[8]) begin have_prev = 1'b1; last_cyc = obs_cyc; end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL rr_timeout: got %0d pending expected 0", exp_q.size());
      end
      step();
   endtask

   task automatic test_backpressure();
      logic [9:0] exp;
      int budget = 0;
      load(2, 20, 1);
      push_frame(2, 20);
      while (exp_q.size() > 0 && budget < 200) begin
         m_tready = cyc[0];
         step(); budget++;
         if (obs_gv) begin
            vectors++;
            if (obs_sready !== (obs_mready ? 4'b0100 : 4'b0000)) begin
               miscompares++; $display("FAIL bp_s_tready: got %b expected %b", obs_sready, obs_mready ? 4'b0100 : 4'b0000);
            end
         end
         vectors++;
         if (obs_abort !== 4'd0) begin
            miscompares++; $display("FAIL bp_abort: got %b expected 0000", obs_abort);
         end
         if (obs_acc) begin
            exp = exp_q.pop_front();
            vectors++;
            if (obs_word !== exp) begin
               miscompares++; $display("FAIL bp_beat: got %h expected %h", obs_word, exp);
            end
         end
      end
      m_tready = 1'b1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL bp_timeout: got %0d pending expected 0", exp_q.size());
      end
      step();
   endtask

   task automatic test_watchdog();
      logic [9:0] exp;
      bit stalled = 1'b0;
      int budget = 0, abort_cnt = 0, last9_cyc = 0, abort_cyc = 0;
      load(1, 30, 1);
      load(2, 4, 1);
      for (int b = 0; b < 10; b++) exp_q.push_back({2'b00, 2'd1, 6'(b)});
      exp_q.push_back(10'h300);
      push_frame(2, 4);
      while (exp_q.size() > 0 && budget < 300) begin
         step(); budget++;
         if (!stalled && src_beat[1] == 10) begin
            stalled = 1'b1; src_hold[1] = 1'b1; drive();
         end
         if (obs_acc) begin
            exp = exp_q.pop_front();
            vectors++;
            if (obs_word !== exp) begin
               miscompares++; $display("FAIL wd_beat: got %h expected %h", obs_word, exp);
            end
            if (exp === 10'h049) last9_cyc = obs_cyc;
         end
         if (obs_abort !== 4'd0) begin
            abort_cnt++; abort_cyc = obs_cyc;
            vectors++;
            if (obs_abort !== 4'b0010) begin
               miscompares++; $display("FAIL wd_abort_port: got %b expected 0010", obs_abort);
            end
            vectors++;
            if (obs_cyc - last9_cyc !== 17) begin
               miscompares++; $display("FAIL wd_abort_time: got %0d expected 17", obs_cyc - last9_cyc);
            end
         end
         if (abort_cnt > 0 && obs_cyc > abort_cyc && obs_gv && obs_gi == 2'd1) begin
            vectors++;
            if (obs_mvalid !== 1'b0 || obs_sready !== 4'b0010) begin
               miscompares++; $display("FAIL wd_drop: got mvalid=%b s_tready=%b expected 0/0010", obs_mvalid, obs_sready);
            end
         end
         if (src_hold[1] && abort_cnt > 0 && cyc >= abort_cyc + 4) begin
            src_hold[1] = 1'b0; drive();
         end
      end
      vectors++;
      if (abort_cnt !== 1) begin
         miscompares++; $display("FAIL wd_abort_count: got %0d expected 1", abort_cnt);
      end
      vectors++;
      if (src_frames[1] !== 0) begin
         miscompares++; $display("FAIL wd_drained: got %0d frames left expected 0", src_frames[1]);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL wd_timeout: got %0d pending expected 0", exp_q.size());
      end
      src_hold = '0;
      step();
   endtask

   task automatic test_enable();
      logic [9:0] exp;
      int budget = 0;
      bit got_first = 1'b0;
      enable = 1'b0;
      for (int p = 0; p < 4; p++) load(p, 8, 1);
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++;
         if (obs_mvalid !== 1'b0 || obs_gv !== 1'b0) begin
            miscompares++; $display("FAIL en_gated: got mvalid=%b gv=%b expected 0/0", obs_mvalid, obs_gv);
         end
      end
      push_frame(3, 8);
      enable = 1'b1;
      while (exp_q.size() > 0 && budget < 100) begin
         step(); budget++;
         if (obs_acc) begin
            exp = exp_q.pop_front();
            vectors++;
            if (obs_word !== exp) begin
               miscompares++; $display("FAIL en_beat: got %h expected %h", obs_word, exp);
            end
            if (!got_first) begin got_first = 1'b1; enable = 1'b0; end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL en_timeout: got %0d pending expected 0", exp_q.size());
      end
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++;
         if (obs_mvalid !== 1'b0 || obs_gv !== 1'b0) begin
            miscompares++; $display("FAIL en_no_regrant: got mvalid=%b gv=%b expected 0/0", obs_mvalid, obs_gv);
         end
      end
      enable = 1'b1;
      for (int p = 0; p < 3; p++) push_frame(p, 8);
      budget = 0;
      while (exp_q.size() > 0 && budget < 200) begin
         step(); budget++;
         if (obs_acc) begin
            exp = exp_q.pop_front();
            vectors++;
            if (obs_word !== exp) begin
               miscompares++; $display("FAIL en_resume_beat: got %h expected %h", obs_word, exp);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL en_resume_timeout: got %0d pending expected 0", exp_q.size());
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp;
      bit first = 1'b1, have_prev = 1'b0;
      int last_cyc = 0, budget = 0;
      load(0, 4, 3);
      for (int f = 0; f < 3; f++) push_frame(0, 4);
      while (exp_q.size() > 0 && budget < 100) begin
         step(); budget++;
         if (obs_acc) begin
            exp = exp_q.pop_front();
            vectors++;
            if (obs_word !== exp || obs_gi !== 2'd0) begin
               miscompares++; $display("FAIL b2b_beat: got %h/%0d expected %h/0", obs_word, obs_gi, exp);
            end
            if (first && have_prev) begin
               vectors++;
               if (obs_cyc - last_cyc !== 2) begin
                  miscompares++; $display("FAIL b2b_gap: got %0d expected 2", obs_cyc - last_cyc);
               end
            end
            first = exp[8];
            if (exp[8]) begin have_prev = 1'b1; last_cyc = obs_cyc; end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL b2b_timeout: got %0d pending expected 0", exp_q.size());
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic [9:0] exp;
      bit first = 1'b1;
      int budget = 0;
      load(3, 20, 1);
      while (src_beat[3] != 5 && budget < 50) begin step(); budget++; end
      vectors++;
      if (src_beat[3] != 5) begin
         miscompares++; $display("FAIL rm_reach_beat5: got %0d expected 5", src_beat[3]);
      end
      rst_n = 1'b0;
      step(); step();
      vectors++;
      if ({obs_mvalid, obs_word, obs_sready} !== 15'd0) begin
         miscompares++; $display("FAIL rm_outputs: got %h expected 0", {obs_mvalid, obs_word, obs_sready});
      end
      vectors++;
      if ({obs_gv, obs_abort, obs_gi} !== 7'd0) begin
         miscompares++; $display("FAIL rm_grant: got %b expected 0", {obs_gv, obs_abort, obs_gi});
      end
      exp_q.delete();
      load(0, 4, 1);
      load(3, 6, 1);
      push_frame(0, 4);
      push_frame(3, 6);
      rst_n = 1'b1;
      budget = 0;
      while (exp_q.size() > 0 && budget < 100) begin
         step(); budget++;
         if (obs_acc) begin
            exp = exp_q.pop_front();
            vectors++;
            if (obs_word !== exp) begin
               miscompares++; $display("FAIL rm_beat: got %h expected %h", obs_word, exp);
            end
            if (first) begin
               first = 1'b0;
               vectors++;
               if (obs_gi !== 2'd0) begin
                  miscompares++; $display("FAIL rm_first_grant: got %0d expected 0", obs_gi);
               end
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL rm_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_backpressure();
      test_watchdog();
      test_enable();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
